// File: rtl/fns_decoder_7_2_if.sv
// Handshake bundle for the FNS receive decoder: codeword/enable input side
// and recovered-data output side, each with its own valid/ready pair.
interface fns_decoder_7_2_if #(
   parameter int DW = 7
);
   logic [8:0]    code_in;
   logic [8:0]    en_flag;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] data_out;
   logic          out_valid;
   logic          out_ready;
   logic          out_err;

   modport master (
      output code_in,
      output en_flag,
      output in_valid,
      input  in_ready,
      input  data_out,
      input  out_valid,
      output out_ready,
      input  out_err
   );

   modport slave (
      input  code_in,
      input  en_flag,
      input  in_valid,
      output in_ready,
      output data_out,
      output out_valid,
      input  out_ready,
      output out_err
   );
endinterface

// File: rtl/fns_decoder_7_2.sv
// Two-stage FNS codeword decoder: masked weighted sum of 9 code bits.
// Optional overflow flag on out_err when FNS_DEC_OVF_CHECK_EN is defined.
module fns_decoder_7_2 #(
   parameter int DW = 7,
   parameter int WW = 7
) (
   input  logic            clock,
   input  logic            rst_n,
   input  logic [8*WW-1:0] fns_w,
   fns_decoder_7_2_if.slave bus
);
   localparam int CW = 9;
   localparam int SW = WW + 4;

   logic [CW-1:0] w_m;
   logic [SW-1:0] w_t [0:CW-1];
   logic [SW-1:0] w_p0, w_p1, w_p2, w_p3, w_p4;
   logic          w_adv;
   logic          w_in_ready;
   logic          w_load1;
   logic          w_load2;

   logic          r_v1;
   logic          r_v2;
   logic [SW-1:0] r_p0, r_p1, r_p2, r_p3, r_p4;
   logic [DW-1:0] r_data;

   assign w_m = bus.code_in & bus.en_flag;

   // W[0] is the implicit constant 1; W[k] for k>=1 comes from fns_w.
   always_comb begin
      w_t[0] = SW'(w_m[0]);
      for (int unsigned k = 1; k < CW; k++) begin
         w_t[k] = w_m[k] ? SW'(fns_w[k*WW-1 -: WW]) : '0;
      end
   end

   assign w_p0 = w_t[0] + w_t[1];
   assign w_p1 = w_t[2] + w_t[3];
   assign w_p2 = w_t[4] + w_t[5];
   assign w_p3 = w_t[6] + w_t[7];
   assign w_p4 = w_t[8];

   assign w_adv      = bus.out_ready || !r_v2;
   assign w_in_ready = !r_v1 || w_adv;
   assign w_load1    = w_in_ready && bus.in_valid;
   assign w_load2    = w_adv && r_v1;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_p0 <= '0;
         r_p1 <= '0;
         r_p2 <= '0;
         r_p3 <= '0;
         r_p4 <= '0;
      end else begin
         if (w_in_ready) r_v1 <= bus.in_valid;
         if (w_load1) begin
            r_p0 <= w_p0;
            r_p1 <= w_p1;
            r_p2 <= w_p2;
            r_p3 <= w_p3;
            r_p4 <= w_p4;
         end
      end
   end

`ifdef FNS_DEC_OVF_CHECK_EN
   logic [SW-1:0] w_sum;
   logic          r_err;

   assign w_sum = r_p0 + r_p1 + r_p2 + r_p3 + r_p4;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_load2) begin
         r_err <= |w_sum[SW-1:DW];
      end
   end

   assign bus.out_err = r_err;
`else
   // Without the flag only the low DW bits of the sum are observable.
   logic [DW-1:0] w_sum;

   assign w_sum = DW'(r_p0) + DW'(r_p1) + DW'(r_p2) + DW'(r_p3) + DW'(r_p4);
   assign bus.out_err = 1'b0;
`endif

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_v2   <= 1'b0;
         r_data <= '0;
      end else begin
         if (w_adv)   r_v2   <= r_v1;
         if (w_load2) r_data <= w_sum[DW-1:0];
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_v2;
   assign bus.data_out  = r_data;
endmodule

// File: tb/tb_fns_decoder_7_2.sv
// Directed bench for fns_decoder_7_2 with hand-computed expected sums.
module tb_fns_decoder_7_2;
   localparam int DW = 7;
   localparam int WW = 7;

   logic            clock = 1'b0;
   logic            rst_n = 1'b0;
   logic [8*WW-1:0] fns_w;

   int n_chk = 0;
   int n_err = 0;

   logic [8:0] q_code[$];
   logic [8:0] q_en[$];
   int         q_exp[$];
   int         q_err[$];

   always #5 clock = ~clock;

   fns_decoder_7_2_if #(.DW(DW)) bus ();

   fns_decoder_7_2 #(.DW(DW), .WW(WW)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .fns_w (fns_w),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_weights(input int w1, w2, w3, w4, w5, w6, w7, w8);
      int w[8];
      w = '{w1, w2, w3, w4, w5, w6, w7, w8};
      for (int k = 0; k < 8; k++) fns_w[k*WW +: WW] = WW'(w[k]);
   endtask

   task automatic add_word(input logic [8:0] code, input logic [8:0] en, input int exp, input int err);
      q_code.push_back(code);
      q_en.push_back(en);
      q_exp.push_back(exp);
      q_err.push_back(err);
   endtask

   // Streams the queued words; out_ready is low for the first 'stall' cycles.
   task automatic run_stream(input string tag, input int stall);
      int n, idx, nout, cyc, nacc_stall, first, last;
      logic acc;
      n = q_code.size();
      idx = 0; nout = 0; cyc = 0; nacc_stall = 0; first = -1; last = -1;
      while (nout < n && cyc < 60) begin
         bus.out_ready = (cyc >= stall);
         bus.in_valid  = (idx < n);
         if (idx < n) begin
            bus.code_in = q_code[idx];
            bus.en_flag = q_en[idx];
         end
         #1;
         if (bus.out_valid) begin
            if (bus.out_ready) begin
               check({tag, "_data"}, 32'(bus.data_out), 32'(q_exp.pop_front()));
               check({tag, "_err"}, 32'(bus.out_err), 32'(q_err.pop_front()));
               if (first < 0) first = cyc;
               last = cyc;
               nout++;
            end else begin
               check({tag, "_hold"}, 32'(bus.data_out), 32'(q_exp[0]));
            end
         end
         acc = bus.in_valid && bus.in_ready;
         if (acc && cyc < stall) nacc_stall++;
         tick();
         if (acc) idx++;
         cyc++;
      end
      bus.in_valid = 1'b0;
      if (nout < n) check({tag, "_timeout"}, 32'(nout), 32'(n));
      if (stall == 0) check({tag, "_nogap"}, 32'(last - first), 32'(n - 1));
      else            check({tag, "_acc_stall"}, 32'(nacc_stall), 32'd2);
      q_code.delete();
      q_en.delete();
      q_exp.delete();
      q_err.delete();
   endtask

   initial begin
      int ovf_err;
`ifdef FNS_DEC_OVF_CHECK_EN
      ovf_err = 1;
`else
      ovf_err = 0;
`endif
      set_weights(1, 2, 3, 5, 8, 13, 21, 34);
      bus.code_in   = '0;
      bus.en_flag   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #12;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", 32'(bus.data_out), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_err", 32'(bus.out_err), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single word: 34 + 1, visible one edge after stage 1 captures it.
      bus.code_in  = 9'b100000001;
      bus.en_flag  = 9'h1FF;
      bus.in_valid = 1'b1;
      #1;
      check("single_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("single_lat1", 32'(bus.out_valid), 32'd0);
      tick();
      check("single_lat2", 32'(bus.out_valid), 32'd1);
      check("single_data", 32'(bus.data_out), 32'd35);
      tick();
      check("single_drained", 32'(bus.out_valid), 32'd0);
      check("single_keep", 32'(bus.data_out), 32'd35);

      add_word(9'h1FF, 9'h1FF, 88, 0);
      add_word(9'h1FF, 9'h0FF, 54, 0);
      add_word(9'h1FF, 9'h000, 0, 0);
      run_stream("mask", 0);

      add_word(9'h001, 9'h1FF, 1, 0);
      add_word(9'h002, 9'h1FF, 1, 0);
      add_word(9'h004, 9'h1FF, 2, 0);
      add_word(9'h100, 9'h1FF, 34, 0);
      add_word(9'h155, 9'h1FF, 55, 0);
      run_stream("b2b", 0);

      add_word(9'h003, 9'h1FF, 2, 0);
      add_word(9'h018, 9'h1FF, 8, 0);
      add_word(9'h0A0, 9'h1FF, 29, 0);
      add_word(9'h041, 9'h1FF, 14, 0);
      add_word(9'h1FF, 9'h155, 55, 0);
      run_stream("bp", 4);

      // Fill both stages, then reset asynchronously between edges.
      bus.out_ready = 1'b0;
      bus.code_in   = 9'h100;
      bus.en_flag   = 9'h1FF;
      bus.in_valid  = 1'b1;
      tick();
      bus.code_in = 9'h002;
      tick();
      bus.in_valid = 1'b0;
      #1;
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      check("pre_rst_data", 32'(bus.data_out), 32'd34);
      check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_data", 32'(bus.data_out), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      #2;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check("post_rst_no_replay", 32'(bus.out_valid), 32'd0);

      set_weights(20, 20, 20, 20, 20, 20, 20, 20);
      add_word(9'h1FF, 9'h1FF, 33, ovf_err);
      add_word(9'h001, 9'h1FF, 1, 0);
      run_stream("ovf", 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
